vegeta_weight_loader: RTL
=========================

// Module: vegeta_weight_loader
// PURPOSE
//  Transmit side of the PU weight chain: drives weight_in / weight_transferring_in / i_wb at the
//  head of a column of NUM_ROWS chained vegeta_pu rows. Accepts one compressed weight row per
//  beat (BETA lanes of value+metadata) from the weight buffer over valid/ready, streams exactly
//  NUM_ROWS beats per tile into the shadow buffer, tracks fullness of both weight buffers, and
//  tells compute which buffer holds a loaded tile.
// PARAMETERS
//  BETA            4   lanes per PU row
//  MUL_DATAWIDTH   8   weight value width
//  META_DATA_SIZE  2   per-lane sparsity metadata width
//  NUM_ROWS        16  PU rows in the chain = beats per tile (>=1)
// PORTS
//  clk                     in   1              clock
//  rst_n                   in   1              async active-low reset
//  start                   in   1              tile load request; honoured only when start_ready
//  start_ready             out  1              IDLE and target buffer free
//  s_data                  in   BETA*(MUL_DATAWIDTH+META_DATA_SIZE)  weight row, lane i at [i*W +: W]
//  s_valid                 in   1              s_data valid
//  s_ready                 out  1              loader accepts s_data this cycle
//  weight_out              out  BETA*(MUL_DATAWIDTH+META_DATA_SIZE)  to first PU weight_in
//  weight_transferring_out out  1              to PU weight_transferring_in; chain shifts when high
//  wb_out                  out  1              to PU i_wb; buffer being loaded, aligned with weight_out
//  compute_buf             out  1              buffer compute must read
//  compute_valid           out  1              compute_buf holds a complete tile
//  buf_release             in   1              compute finished with compute_buf (pulse)
//  tile_done               out  1              1-cycle pulse: last beat of tile on weight_out
//  busy                    out  1              state==LOAD
// BEHAVIOUR
//  - Reset: state IDLE, row_cnt=0, wr_ptr=0, rd_ptr=0, buf_full=2'b00; all outputs 0
//    (weight_out=0, weight_transferring_out=0, wb_out=0, tile_done=0). Reset mid-tile discards it.
//  - FSM IDLE->LOAD on start && start_ready; row_cnt<=0. start while !start_ready ignored (not queued).
//  - start_ready = (state==IDLE) && !buf_full[wr_ptr].  s_ready = (state==LOAD).
//  - LOAD: beat = s_valid && s_ready. Registered, 1-cycle latency: on beat, weight_out<=s_data,
//    weight_transferring_out<=1, wb_out<=wr_ptr; else weight_transferring_out<=0, weight_out and
//    wb_out hold. s_valid gaps give transfer bubbles; the chain holds, beat count unaffected.
//  - row_cnt (width vegeta_clog2(NUM_ROWS)) increments per beat; beat with row_cnt==NUM_ROWS-1:
//    state<=IDLE, buf_full[wr_ptr]<=1, wr_ptr<=~wr_ptr, tile_done<=1 (next cycle, aligned with last
//    weight on weight_out). First beat of a tile ends in the deepest PU row.
//  - compute_buf = rd_ptr; compute_valid = buf_full[rd_ptr].
//  - buf_release && compute_valid: buf_full[rd_ptr]<=0, rd_ptr<=~rd_ptr. Ignored if !compute_valid.
//  - Same-cycle release and tile completion touch different buffers; both take effect.
//  - Both buffers full: start_ready=0 until a release; the next start is accepted one cycle after it.
//  - Back-to-back tiles: start in the IDLE cycle after tile_done -> no dead cycle beyond that one.
// STRUCTURE
//  - Package vegeta_pkg: weight lane width localparam W=MUL_DATAWIDTH+META_DATA_SIZE, FSM enum
//    {IDLE,LOAD}, vegeta_clog2 macro shared with PU.
//  - One natural sub-module: vegeta_wbuf_tracker (wr_ptr/rd_ptr/buf_full, start_ready, compute_valid).
//  - Loader FSM, row counter and output register stage stay in this module.
// TESTING (BETA=4, MUL=8, META=2, NUM_ROWS=4)
//  - Reset, start, 4 back-to-back beats rows 0x11..0x44 -> weight_transferring_out high 4 cycles,
//    wb_out=0, tile_done 1 cycle with 0x44 on weight_out, compute_valid=1, compute_buf=0.
//  - s_valid 1,0,0,1,1,0,1 -> exactly 4 transfer cycles with 0-gaps matching; weight_out held in gaps.
//  - Two tiles, no release -> second loads with wb_out=1; start_ready=0; start ignored;
//    buf_release -> compute_buf=1, start_ready=1 next cycle.
//  - buf_release while compute_valid=0 -> no pointer/flag change.
//  - Release of buf 0 in same cycle as last beat into buf 1 -> buf_full=2'b10, rd_ptr=1.
//  - rst_n low after beat 2 of a tile -> all outputs 0, buf_full=0, new start reloads from row 0.

Source files
------------

// File: rtl/vegeta_pkg.sv
// Shared definitions for the vegeta PU weight path.
//   - default geometry of a PU row (lanes, value/metadata widths, chain depth)
//   - W: width of one compressed weight lane (value + sparsity metadata)
//   - loader FSM state constants
//   - vegeta_clog2: counter-width helper shared with the PU
package vegeta_pkg;

   localparam int BETA_DEF           = 4;
   localparam int MUL_DATAWIDTH_DEF  = 8;
   localparam int META_DATA_SIZE_DEF = 2;
   localparam int NUM_ROWS_DEF       = 16;

   localparam int W = MUL_DATAWIDTH_DEF + META_DATA_SIZE_DEF;

   typedef logic [0:0] ld_state_t;
   localparam ld_state_t IDLE = 1'b0;
   localparam ld_state_t LOAD = 1'b1;

   // Bits needed to count 0..value-1; never less than 1 so a
   // single-row chain still gets a legal counter.
   function automatic int vegeta_clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vegeta_weight_loader_if.sv
// Weight-row stream from the weight buffer into the loader.
//   s_data  : one compressed weight row, lane i at [i*W +: W]
//   s_valid : s_data valid
//   s_ready : loader accepts s_data this cycle
// master = weight buffer side, slave = loader side.
interface vegeta_weight_loader_if
   import vegeta_pkg::*;
#(
   parameter int DW = BETA_DEF * W
);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/vegeta_wbuf_tracker.sv
// Double-buffer bookkeeping for the PU weight buffers.
//   clk, rst_n     : clock, async active-low reset
//   fsm_idle       : loader is idle (may accept a new tile)
//   tile_commit    : last beat of a tile this cycle; the buffer at wr_ptr becomes full
//   buf_release    : compute finished with compute_buf (pulse)
//   start_ready    : idle and the write target buffer is free
//   wr_ptr         : buffer currently being (or next to be) loaded
//   compute_buf    : buffer compute must read (rd_ptr)
//   compute_valid  : compute_buf holds a complete tile
module vegeta_wbuf_tracker (
   input  logic clk,
   input  logic rst_n,
   input  logic fsm_idle,
   input  logic tile_commit,
   input  logic buf_release,
   output logic start_ready,
   output logic wr_ptr,
   output logic compute_buf,
   output logic compute_valid
);

   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] buf_full_q, buf_full_d;

   // A commit always targets a buffer that was free at start, and a release
   // only acts on a full buffer, so the two never hit the same entry.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      buf_full_d = buf_full_q;
      if (tile_commit) begin
         buf_full_d[wr_ptr_q] = 1'b1;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (buf_release && buf_full_q[rd_ptr_q]) begin
         buf_full_d[rd_ptr_q] = 1'b0;
         rd_ptr_d             = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         buf_full_q <= 2'b00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         buf_full_q <= buf_full_d;
      end
   end

   assign start_ready   = fsm_idle && !buf_full_q[wr_ptr_q];
   assign wr_ptr        = wr_ptr_q;
   assign compute_buf   = rd_ptr_q;
   assign compute_valid = buf_full_q[rd_ptr_q];

endmodule

// File: rtl/vegeta_weight_loader.sv
// Transmit side of the PU weight chain. Streams NUM_ROWS weight rows per
// tile from the weight buffer into the shadow buffer of a column of chained
// vegeta_pu rows, and tracks which of the two weight buffers holds a tile.
//   clk, rst_n              : clock, async active-low reset
//   start / start_ready     : tile load request / loader can take one
//   s_if (slave)            : weight-row stream (s_data, s_valid, s_ready)
//   weight_out              : to first PU weight_in (registered)
//   weight_transferring_out : chain shifts when high (registered)
//   wb_out                  : buffer being loaded, aligned with weight_out
//   compute_buf/_valid      : buffer compute reads / it holds a full tile
//   buf_release             : compute done with compute_buf (pulse)
//   tile_done               : pulse with the last row of a tile on weight_out
//   busy                    : tile load in progress
//
// state | meaning
// IDLE  | waiting for start with a free target buffer
// LOAD  | accepting rows; leaves after NUM_ROWS beats
module vegeta_weight_loader
   import vegeta_pkg::*;
#(
   parameter int BETA           = BETA_DEF,
   parameter int MUL_DATAWIDTH  = MUL_DATAWIDTH_DEF,
   parameter int META_DATA_SIZE = META_DATA_SIZE_DEF,
   parameter int NUM_ROWS       = NUM_ROWS_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   start_ready,
   vegeta_weight_loader_if.slave  s_if,
   output logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
   output logic                   weight_transferring_out,
   output logic                   wb_out,
   output logic                   compute_buf,
   output logic                   compute_valid,
   input  logic                   buf_release,
   output logic                   tile_done,
   output logic                   busy
);

   localparam int DW    = BETA * (MUL_DATAWIDTH + META_DATA_SIZE);
   localparam int CNT_W = vegeta_clog2(NUM_ROWS);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

   ld_state_t        state_q, state_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [DW-1:0]    weight_q, weight_d;
   logic             xfer_q, xfer_d;
   logic             wb_q, wb_d;
   logic             done_q, done_d;

   logic beat;
   logic last_beat;
   logic wr_ptr;

   assign beat      = s_if.s_valid && (state_q == LOAD);
   assign last_beat = beat && (row_cnt_q == LAST_ROW);

   vegeta_wbuf_tracker u_wbuf_tracker (
      .clk           (clk),
      .rst_n         (rst_n),
      .fsm_idle      (state_q == IDLE),
      .tile_commit   (last_beat),
      .buf_release   (buf_release),
      .start_ready   (start_ready),
      .wr_ptr        (wr_ptr),
      .compute_buf   (compute_buf),
      .compute_valid (compute_valid)
   );

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      case (state_q)
         IDLE: begin
            if (start && start_ready) begin
               state_d   = LOAD;
               row_cnt_d = '0;
            end
         end
         default: begin
            if (last_beat) begin
               state_d   = IDLE;
               row_cnt_d = '0;
            end else if (beat) begin
               row_cnt_d = row_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Output stage: on a bubble the chain holds, so data and buffer select
   // keep their last value and only the transfer strobe drops.
   always_comb begin
      weight_d = beat ? s_if.s_data : weight_q;
      wb_d     = beat ? wr_ptr : wb_q;
      xfer_d   = beat;
      done_d   = last_beat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_cnt_q <= '0;
         weight_q  <= '0;
         xfer_q    <= 1'b0;
         wb_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         weight_q  <= weight_d;
         xfer_q    <= xfer_d;
         wb_q      <= wb_d;
         done_q    <= done_d;
      end
   end

   assign s_if.s_ready            = (state_q == LOAD);
   assign busy                    = (state_q == LOAD);
   assign weight_out              = weight_q;
   assign weight_transferring_out = xfer_q;
   assign wb_out                  = wb_q;
   assign tile_done               = done_q;

endmodule
